// File: rtl/mem_req_pkg.sv
// Shared types for the memory request controller: FSM state encoding,
// the default command record layout and the completion counter width.
package mem_req_pkg;

  localparam int CNT_WIDTH      = 16;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  typedef struct packed {
    logic                      wr_rd;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/mem_req_fifo.sv
// Command FIFO for mem_req_ctrl. The head entry is visible on 'head' with no
// read latency so the controller can present it to memory directly.
// Overflow/underflow are blocked internally: push is ignored when full and
// pop is ignored when empty.
module mem_req_fifo
  import mem_req_pkg::*;
#(
  parameter type T     = cmd_t,
  parameter int  DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  T                           din,
  input  logic                       pop,
  output T                           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     occ
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_OCC = DEPTH[PW:0];

  T              mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (occ == FULL_OCC);
  assign empty   = (occ == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rptr];

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= din;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; occupancy tracks fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// Memory request controller: queues upstream write/read commands and issues
// them one at a time to memory over valid/ready. Read data returns on a
// registered response port; completed writes/reads are counted.
// Optional feature macro: MEM_REQ_TIMEOUT_EN (abandon a request that waits
// TIMEOUT cycles for ready, pulsing err).
//
//   state | meaning
//   IDLE  | nothing presented to memory; waits for a queued command
//   REQ   | FIFO head presented with valid=1; waiting for ready
module mem_req_ctrl
  import mem_req_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr_rd,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  wr_rd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  valid,
  input  logic                  ready,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rsp_valid,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [CNT_WIDTH-1:0]  wr_done_cnt,
  output logic [CNT_WIDTH-1:0]  rd_done_cnt,
  output logic                  err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] OCC_ONE = 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_bad_params
    $error("mem_req_ctrl: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT >= 2");
  end

  typedef struct packed {
    logic                  wr_rd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_w_t;

  state_t      state;
  state_t      state_nxt;
  cmd_w_t      cmd_in;
  cmd_w_t      head;
  logic        full;
  logic        empty;
  logic [PW:0] occ;
  logic        hs;
  logic        drop;
  logic        pop;
  logic        more;

  assign cmd_in = '{wr_rd: cmd_wr_rd, addr: cmd_addr, wdata: cmd_wdata};

  mem_req_fifo #(
    .T     (cmd_w_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .din   (cmd_in),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .occ   (occ)
  );

  assign cmd_ready = !full;
  assign hs        = (state == REQ) && ready;
  assign pop       = hs || drop;
  // A successor exists only if something sits behind the entry being retired.
  assign more      = (occ > OCC_ONE);

`ifdef MEM_REQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  logic [WW-1:0] wait_cnt;

  assign drop = (state == REQ) && !ready && (wait_cnt == WAIT_LAST);

  // Ready-wait counter restarts for every newly presented command.
  always_ff @(posedge clk) begin
    if (rst || state != REQ || pop) begin
      wait_cnt <= '0;
    end else if (!ready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign drop = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: retire the head on handshake/timeout, chain successors.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty)       state_nxt = REQ;
      REQ:     if (pop && !more) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-side outputs: the FIFO head drives the bus only while requesting.
  always_comb begin
    valid = (state == REQ);
    wr_rd = 1'b0;
    addr  = '0;
    wdata = '0;
    err   = drop;
    if (valid) begin
      wr_rd = head.wr_rd;
      addr  = head.addr;
      wdata = head.wdata;
    end
  end

  // Completion counters and the registered read response.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid   <= 1'b0;
      rsp_addr    <= '0;
      rsp_rdata   <= '0;
      wr_done_cnt <= '0;
      rd_done_cnt <= '0;
    end else begin
      rsp_valid <= hs && !head.wr_rd;
      if (hs) begin
        if (head.wr_rd) begin
          wr_done_cnt <= wr_done_cnt + 1'b1;
        end else begin
          rd_done_cnt <= rd_done_cnt + 1'b1;
          rsp_addr    <= head.addr;
          rsp_rdata   <= rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Testbench for mem_req_ctrl: per-cycle vector table plus hand sequences for
// response latency and (with MEM_REQ_TIMEOUT_EN) the ready-wait timeout.
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr_rd;
  logic [3:0]  cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        wr_rd;
  logic [3:0]  addr;
  logic [7:0]  wdata;
  logic        valid;
  logic        ready;
  logic [7:0]  rdata;
  logic        rsp_valid;
  logic [3:0]  rsp_addr;
  logic [7:0]  rsp_rdata;
  logic [15:0] wr_done_cnt;
  logic [15:0] rd_done_cnt;
  logic        err;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  mem_req_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_wr_rd   (cmd_wr_rd),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .wr_rd       (wr_rd),
    .addr        (addr),
    .wdata       (wdata),
    .valid       (valid),
    .ready       (ready),
    .rdata       (rdata),
    .rsp_valid   (rsp_valid),
    .rsp_addr    (rsp_addr),
    .rsp_rdata   (rsp_rdata),
    .wr_done_cnt (wr_done_cnt),
    .rd_done_cnt (rd_done_cnt),
    .err         (err)
  );

  // Simple memory model: combinational read, write on handshake.
  logic [7:0] tb_mem [16] = '{2: 8'h77, default: 8'h00};
  assign rdata = tb_mem[addr];
  always @(posedge clk) begin
    if (valid && ready && wr_rd) tb_mem[addr] <= wdata;
  end

  typedef struct {
    logic        rst, cv, cw;
    logic [3:0]  ca;
    logic [7:0]  cd;
    logic        rdy;
    logic        crdy, vld, wr;
    logic [3:0]  a;
    logic [7:0]  d;
    logic        rv;
    logic [3:0]  ra;
    logic [7:0]  rd;
    logic [15:0] wc, rc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst_i, logic cv, logic cw, logic [3:0] ca, logic [7:0] cd,
                              logic rdy, logic crdy, logic vld, logic wr, logic [3:0] a,
                              logic [7:0] d, logic rv, logic [3:0] ra, logic [7:0] rd,
                              logic [15:0] wc, logic [15:0] rc);
    vec_t v;
    v.rst = rst_i; v.cv = cv; v.cw = cw; v.ca = ca; v.cd = cd; v.rdy = rdy;
    v.crdy = crdy; v.vld = vld; v.wr = wr; v.a = a; v.d = d;
    v.rv = rv; v.ra = ra; v.rd = rd; v.wc = wc; v.rc = rc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    logic [63:0] act_v, exp_v;
    int          nvld;
    logic        seen;

    rst = 1'b1; cmd_valid = 1'b0; cmd_wr_rd = 1'b0; cmd_addr = '0; cmd_wdata = '0; ready = 1'b1;

    //            rst cv cw ca     cd      rdy  crdy vld wr a      d      rv ra     rd     wc      rc
    // reset state
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 1,   1, 0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 16'd0,  16'd0));
    // single write
    vecs.push_back(mk(0, 1, 1, 4'h3, 8'hA5, 1,   1, 0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 16'd0,  16'd0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 1,   1, 0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 16'd0,  16'd0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 1,   1, 1, 1, 4'h3, 8'hA5, 0, 4'h0, 8'h00, 16'd0,  16'd0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 1,   1, 0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 16'd1,  16'd0));
    // write then read same address
    vecs.push_back(mk(0, 1, 1, 4'h5, 8'h3C, 1,   1, 0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 16'd1,  16'd0));
    vecs.push_back(mk(0, 1, 0, 4'h5, 8'h00, 1,   1, 0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 16'd1,  16'd0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 1,   1, 1, 1, 4'h5, 8'h3C, 0, 4'h0, 8'h00, 16'd1,  16'd0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 1,   1, 1, 0, 4'h5, 8'h00, 0, 4'h0, 8'h00, 16'd2,  16'd0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 1,   1, 0, 0, 4'h0, 8'h00, 1, 4'h5, 8'h3C, 16'd2,  16'd1));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 1,   1, 0, 0, 4'h0, 8'h00, 0, 4'h5, 8'h3C, 16'd2,  16'd1));
    // backpressure: read addr 2 held for 6 cycles
    vecs.push_back(mk(0, 1, 0, 4'h2, 8'h00, 0,   1, 0, 0, 4'h0, 8'h00, 0, 4'h5, 8'h3C, 16'd2,  16'd1));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 0,   1, 0, 0, 4'h0, 8'h00, 0, 4'h5, 8'h3C, 16'd2,  16'd1));
    for (int k = 0; k < 6; k++)
      vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 0, 1, 1, 0, 4'h2, 8'h00, 0, 4'h5, 8'h3C, 16'd2,  16'd1));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 1,   1, 1, 0, 4'h2, 8'h00, 0, 4'h5, 8'h3C, 16'd2,  16'd1));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 1,   1, 0, 0, 4'h0, 8'h00, 1, 4'h2, 8'h77, 16'd2,  16'd2));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 1,   1, 0, 0, 4'h0, 8'h00, 0, 4'h2, 8'h77, 16'd2,  16'd2));
    // FIFO full: five writes while ready=0
    vecs.push_back(mk(0, 1, 1, 4'h8, 8'h10, 0,   1, 0, 0, 4'h0, 8'h00, 0, 4'h2, 8'h77, 16'd2,  16'd2));
    vecs.push_back(mk(0, 1, 1, 4'h9, 8'h11, 0,   1, 0, 0, 4'h0, 8'h00, 0, 4'h2, 8'h77, 16'd2,  16'd2));
    vecs.push_back(mk(0, 1, 1, 4'hA, 8'h12, 0,   1, 1, 1, 4'h8, 8'h10, 0, 4'h2, 8'h77, 16'd2,  16'd2));
    vecs.push_back(mk(0, 1, 1, 4'hB, 8'h13, 0,   1, 1, 1, 4'h8, 8'h10, 0, 4'h2, 8'h77, 16'd2,  16'd2));
    vecs.push_back(mk(0, 1, 1, 4'hC, 8'h14, 0,   0, 1, 1, 4'h8, 8'h10, 0, 4'h2, 8'h77, 16'd2,  16'd2));
    vecs.push_back(mk(0, 1, 1, 4'hC, 8'h14, 1,   0, 1, 1, 4'h8, 8'h10, 0, 4'h2, 8'h77, 16'd2,  16'd2));
    vecs.push_back(mk(0, 1, 1, 4'hC, 8'h14, 0,   1, 1, 1, 4'h9, 8'h11, 0, 4'h2, 8'h77, 16'd3,  16'd2));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 1,   0, 1, 1, 4'h9, 8'h11, 0, 4'h2, 8'h77, 16'd3,  16'd2));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 1,   1, 1, 1, 4'hA, 8'h12, 0, 4'h2, 8'h77, 16'd4,  16'd2));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 1,   1, 1, 1, 4'hB, 8'h13, 0, 4'h2, 8'h77, 16'd5,  16'd2));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 1,   1, 1, 1, 4'hC, 8'h14, 0, 4'h2, 8'h77, 16'd6,  16'd2));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 1,   1, 0, 0, 4'h0, 8'h00, 0, 4'h2, 8'h77, 16'd7,  16'd2));
    // throughput: four queued writes drained at one per cycle
    vecs.push_back(mk(0, 1, 1, 4'h0, 8'h20, 0,   1, 0, 0, 4'h0, 8'h00, 0, 4'h2, 8'h77, 16'd7,  16'd2));
    vecs.push_back(mk(0, 1, 1, 4'h1, 8'h21, 0,   1, 0, 0, 4'h0, 8'h00, 0, 4'h2, 8'h77, 16'd7,  16'd2));
    vecs.push_back(mk(0, 1, 1, 4'h2, 8'h22, 0,   1, 1, 1, 4'h0, 8'h20, 0, 4'h2, 8'h77, 16'd7,  16'd2));
    vecs.push_back(mk(0, 1, 1, 4'h3, 8'h23, 0,   1, 1, 1, 4'h0, 8'h20, 0, 4'h2, 8'h77, 16'd7,  16'd2));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 1,   0, 1, 1, 4'h0, 8'h20, 0, 4'h2, 8'h77, 16'd7,  16'd2));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 1,   1, 1, 1, 4'h1, 8'h21, 0, 4'h2, 8'h77, 16'd8,  16'd2));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 1,   1, 1, 1, 4'h2, 8'h22, 0, 4'h2, 8'h77, 16'd9,  16'd2));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 1,   1, 1, 1, 4'h3, 8'h23, 0, 4'h2, 8'h77, 16'd10, 16'd2));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 1,   1, 0, 0, 4'h0, 8'h00, 0, 4'h2, 8'h77, 16'd11, 16'd2));
    // reset while a request is in flight with two more queued
    vecs.push_back(mk(0, 1, 1, 4'h4, 8'h30, 0,   1, 0, 0, 4'h0, 8'h00, 0, 4'h2, 8'h77, 16'd11, 16'd2));
    vecs.push_back(mk(0, 1, 0, 4'h5, 8'h00, 0,   1, 0, 0, 4'h0, 8'h00, 0, 4'h2, 8'h77, 16'd11, 16'd2));
    vecs.push_back(mk(0, 1, 1, 4'h6, 8'h31, 0,   1, 1, 1, 4'h4, 8'h30, 0, 4'h2, 8'h77, 16'd11, 16'd2));
    vecs.push_back(mk(1, 0, 0, 4'h0, 8'h00, 0,   1, 1, 1, 4'h4, 8'h30, 0, 4'h2, 8'h77, 16'd11, 16'd2));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 1,   1, 0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 16'd0,  16'd0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 1,   1, 0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 16'd0,  16'd0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 1,   1, 0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 16'd0,  16'd0));

    @(negedge clk);
    @(negedge clk);

    foreach (vecs[i]) begin
      if (i != 0) @(negedge clk);
      rst       = vecs[i].rst;
      cmd_valid = vecs[i].cv;
      cmd_wr_rd = vecs[i].cw;
      cmd_addr  = vecs[i].ca;
      cmd_wdata = vecs[i].cd;
      ready     = vecs[i].rdy;
      #1;
      act_v = {3'b0, cmd_ready, valid, wr_rd, addr, wdata, rsp_valid, rsp_addr, rsp_rdata,
               wr_done_cnt, rd_done_cnt, err};
      exp_v = {3'b0, vecs[i].crdy, vecs[i].vld, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].rv,
               vecs[i].ra, vecs[i].rd, vecs[i].wc, vecs[i].rc, 1'b0};
      chk($sformatf("vec%0d", i), act_v, exp_v);
    end

    // Read of addr 5 after reset: one request cycle, response two edges after push.
    @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b1; cmd_wr_rd = 1'b0; cmd_addr = 4'h5; cmd_wdata = 8'h00; ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    nvld = 0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (valid) nvld++;
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("rsp_seen", 64'(seen), 64'd1);
    chk("rd_valid_cycles", 64'(nvld), 64'd1);
    chk("rsp_addr", 64'(rsp_addr), 64'h5);
    chk("rsp_rdata", 64'(rsp_rdata), 64'h3C);
    chk("rd_done_cnt", 64'(rd_done_cnt), 64'd1);
    @(negedge clk);
    #1;
    chk("rsp_pulse_width", 64'(rsp_valid), 64'd0);

`ifdef MEM_REQ_TIMEOUT_EN
    // Read to addr 1 never gets ready; it is dropped on its 16th request cycle
    // and the queued write to addr 7 issues right after.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr_rd = 1'b0; cmd_addr = 4'h1; ready = 1'b0;
    @(negedge clk);
    cmd_wr_rd = 1'b1; cmd_addr = 4'h7; cmd_wdata = 8'h55;
    @(negedge clk);
    cmd_valid = 1'b0;
    nvld = 0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (valid) nvld++;
      if (rsp_valid) chk("no_rsp_on_timeout", 64'(rsp_valid), 64'd0);
      if (err) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("err_seen", 64'(seen), 64'd1);
    chk("err_req_cycle", 64'(nvld), 64'd16);
    @(negedge clk);
    #1;
    chk("err_width", 64'(err), 64'd0);
    chk("next_cmd_issue", 64'({valid, wr_rd, addr}), 64'({1'b1, 1'b1, 4'h7}));
    ready = 1'b1;
    @(negedge clk);
    #1;
    chk("cnt_after_timeout", 64'({wr_done_cnt, rd_done_cnt, valid}), 64'({16'd1, 16'd1, 1'b0}));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
